// File: rtl/pwr_seq_ctrl_if.sv
// Control/config and status bundle between the measurement harness and pwr_seq_ctrl.
interface pwr_seq_ctrl_if #(
  parameter int unsigned NUM_MODULES = 32,
  parameter int unsigned DWELL_W     = 32,
  parameter int unsigned STEP_W      = 16
);
  logic                   start;
  logic                   abort;
  logic [NUM_MODULES-1:0] target_mask;
  logic [STEP_W-1:0]      step_cycles;
  logic [DWELL_W-1:0]     dwell_cycles;
  logic [NUM_MODULES-1:0] pwr_en_out;
  logic [6:0]             en_count;
  logic [1:0]             state_o;
  logic                   busy;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, abort, target_mask, step_cycles, dwell_cycles,
    input  pwr_en_out, en_count, state_o, busy, done, aborted
  );

  modport slave (
    input  start, abort, target_mask, step_cycles, dwell_cycles,
    output pwr_en_out, en_count, state_o, busy, done, aborted
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Ramps a power-enable vector up one bit per step, dwells at full mask, then ramps
// down in reverse order; abort jumps straight to the ramp-down.
module pwr_seq_ctrl #(
  parameter int unsigned NUM_MODULES = 32,
  parameter int unsigned DWELL_W     = 32,
  parameter int unsigned STEP_W      = 16
) (
  input  logic            clk100m,
  input  logic            rstn,
  pwr_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    DWELL     = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                 state;
  logic [NUM_MODULES-1:0] mask_q;
  logic [NUM_MODULES-1:0] pwr_en;
  logic [6:0]             en_cnt;
  logic [STEP_W-1:0]      step_q;
  logic [DWELL_W-1:0]     dwell_q;
  logic [STEP_W-1:0]      step_cnt;
  logic [DWELL_W-1:0]     dwell_cnt;
  logic                   done_q;
  logic                   aborted_q;

  logic [NUM_MODULES-1:0] avail;
  logic [NUM_MODULES-1:0] set_bit;
  logic [NUM_MODULES-1:0] clr_bit;
  logic [STEP_W-1:0]      step_in;

  assign step_in = (bus.step_cycles == '0) ? STEP_W'(1) : bus.step_cycles;

  // set_bit: lowest still-missing mask bit; clr_bit: highest currently-enabled bit
  always_comb begin
    avail   = mask_q & ~pwr_en;
    set_bit = '0;
    for (int unsigned i = NUM_MODULES; i > 0; i--) begin
      if (avail[i-1]) begin
        set_bit      = '0;
        set_bit[i-1] = 1'b1;
      end
    end
    clr_bit = '0;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      if (pwr_en[i]) begin
        clr_bit    = '0;
        clr_bit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      mask_q    <= '0;
      pwr_en    <= '0;
      en_cnt    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q    <= bus.target_mask;
            step_q    <= step_in;
            dwell_q   <= bus.dwell_cycles;
            aborted_q <= 1'b0;
            step_cnt  <= step_in - STEP_W'(1);
            // An empty mask completes on the accepting edge without ever going busy
            if (bus.target_mask == '0) done_q <= 1'b1;
            else                       state  <= RAMP_UP;
          end
        end

        RAMP_UP: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            step_cnt  <= step_q - STEP_W'(1);
            if (pwr_en == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state <= RAMP_DOWN;
            end
          end else if (step_cnt != '0) begin
            step_cnt <= step_cnt - STEP_W'(1);
          end else begin
            pwr_en   <= pwr_en | set_bit;
            en_cnt   <= en_cnt + 7'd1;
            step_cnt <= step_q - STEP_W'(1);
            if ((pwr_en | set_bit) == mask_q) begin
              if (dwell_q != '0) begin
                state     <= DWELL;
                dwell_cnt <= dwell_q - DWELL_W'(1);
              end else begin
                state <= RAMP_DOWN;
              end
            end
          end
        end

        DWELL: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            step_cnt  <= step_q - STEP_W'(1);
            if (pwr_en == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state <= RAMP_DOWN;
            end
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end else begin
            state    <= RAMP_DOWN;
            step_cnt <= step_q - STEP_W'(1);
          end
        end

        RAMP_DOWN: begin
          if (step_cnt != '0) begin
            step_cnt <= step_cnt - STEP_W'(1);
          end else begin
            pwr_en   <= pwr_en & ~clr_bit;
            en_cnt   <= en_cnt - 7'd1;
            step_cnt <= step_q - STEP_W'(1);
            if ((pwr_en & ~clr_bit) == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwr_en_out = pwr_en;
  assign bus.en_count   = en_cnt;
  assign bus.state_o    = state;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
Sequences the per-module power-enable vector that feeds the DUT array of the power-estimation design. It ramps enables up one module at a time so that supply current steps in controlled increments. It then holds the full pattern for a programmable dwell window and ramps back down in reverse order. The output drives the array's pwr_en_in bus; status outputs let the measurement harness align current samples to each enable step.

Parameters:
NUM_MODULES, 32, width of the enable vector (1..64)
DWELL_W, 32, width of the dwell counter
STEP_W, 16, width of the per-step spacing counter

Ports:
clk100m  in  1  system clock, 100 MHz
rstn  in  1  asynchronous active-low reset
start  in  1  request a sequence; accepted only in IDLE
abort  in  1  request an early ramp-down
target_mask  in  NUM_MODULES  modules to enable; latched on start accept
step_cycles  in  STEP_W  cycles between enable/disable steps; latched on start; 0 is treated as 1
dwell_cycles  in  DWELL_W  hold time at full mask; latched on start; 0 means no dwell
pwr_en_out  out  NUM_MODULES  registered enable vector to the DUT array
en_count  out  7  number of bits set in pwr_en_out (registered)
state_o  out  2  0=IDLE, 1=RAMP_UP, 2=DWELL, 3=RAMP_DOWN
busy  out  1  state_o != IDLE
done  out  1  one-cycle pulse when a sequence ends
aborted  out  1  sticky flag for the last sequence ending via abort; cleared on the next start accept

Behaviour:
- Reset (rstn low, asynchronous), all values held until the first edge after release:
  - state IDLE; pwr_en_out=0, en_count=0, done=0, aborted=0
  - latched mask, S and D cleared; counter=0
- Let S = max(step_cycles,1), D = dwell_cycles, M = popcount(target_mask). All registers update on posedge clk100m.
- IDLE:
  - start=1 at edge T0: latch mask/S/D, clear aborted, counter<=S-1, state<=RAMP_UP.
  - If the latched mask is 0: state stays IDLE and done pulses at T0+1.
  - abort is ignored in IDLE.
- RAMP_UP, on each edge:
  - If counter!=0: decrement.
  - Else: set the lowest bit of (mask & ~pwr_en_out), increment en_count, counter<=S-1.
  - When that bit completes the mask: with D>0, state<=DWELL and counter<=D-1; with D=0, state<=RAMP_DOWN and counter<=S-1.
  - Result: k-th enable appears at edge T0+k*S.
- DWELL: decrement each edge; at counter==0, state<=RAMP_DOWN and counter<=S-1.
- RAMP_DOWN, on each edge:
  - If counter!=0: decrement.
  - Else: clear the highest set bit of pwr_en_out, decrement en_count, counter<=S-1.
  - When pwr_en_out becomes 0: state<=IDLE and done<=1 for exactly one cycle.
- abort in RAMP_UP or DWELL:
  - Next state RAMP_DOWN, counter<=S-1, aborted<=1.
  - No bit is set on that edge, even if the step counter expired the same cycle (abort wins).
  - If pwr_en_out==0 at abort: state<=IDLE and done pulses next cycle.
- abort in RAMP_DOWN is ignored; aborted is not set.
- start while busy is ignored; latched config cannot change mid-sequence.
- Bit selection uses combinational priority encoders over NUM_MODULES bits. At most one bit of pwr_en_out changes per edge.
- Bits outside target_mask are never set.
- Invariant: en_count == popcount(pwr_en_out) at all times.
- Counter widths: the step counter is STEP_W bits and the dwell counter DWELL_W bits. No wrap is possible, because each counter is reloaded before it underflows.

Test Plan:
- Reset: assert rstn low mid-RAMP_UP with pwr_en_out=0x3 -> pwr_en_out=0, state_o=0, en_count=0 immediately, without waiting for a clock edge.
- Basic sequence: mask=0x0000000F, step=4, dwell=10, start at T0 -> bits 0,1,2,3 set at T0+4/8/12/16; bits 3,2,1,0 clear at T0+30/34/38/42; done high for one cycle after the T0+42 edge; aborted=0.
- Sparse mask with zero config: mask=0x80000001, step=0, dwell=0 -> bit0 at T0+1, bit31 at T0+2, bit31 cleared T0+3, bit0 cleared T0+4, done pulse; en_count trace 1,2,1,0.
- Abort during DWELL: mask=0xFF, step=2, dwell=100, abort 5 cycles into DWELL -> state_o=3 next cycle; bits clear 7..0 every 2 cycles; done pulse; aborted=1.
- Abort colliding with step expiry: same cycle in RAMP_UP -> no new bit set, ramp-down begins. Abort issued while pwr_en_out=0 -> IDLE with a done pulse next cycle.
- Ignored requests and empty mask: start during RAMP_UP with mask=0xFFFF0000 -> sequence unchanged. Start with mask=0 -> done pulse at T0+1, pwr_en_out stays 0, busy never asserts.
